// File: rtl/twos_comp_pkg.sv
// Shared definitions for the multi-lane serial two's-complement negator:
// lane state encoding and default geometry.
package twos_comp_pkg;

   localparam int unsigned DefaultWidth    = 8;
   localparam int unsigned DefaultChannels = 4;

   typedef enum logic {
      StSeek   = 1'b0,
      StInvert = 1'b1
   } lane_state_e;

endpackage

// File: rtl/twos_comp_serial_mc_if.sv
// Beat-level bus of the serial negator: input stream with per-lane negate
// enables, registered output stream with per-lane overflow and framing error.
interface twos_comp_serial_mc_if
   import twos_comp_pkg::*;
#(
   parameter int unsigned CHANNELS = DefaultChannels
);

   logic                in_valid;
   logic                in_sof;
   logic [CHANNELS-1:0] in_bit;
   logic [CHANNELS-1:0] neg_en;
   logic                out_valid;
   logic                out_sof;
   logic                out_eof;
   logic [CHANNELS-1:0] out_bit;
   logic [CHANNELS-1:0] ovf;
   logic                frame_err;

   modport master (
      output in_valid, in_sof, in_bit, neg_en,
      input  out_valid, out_sof, out_eof, out_bit, ovf, frame_err
   );

   modport slave (
      input  in_valid, in_sof, in_bit, neg_en,
      output out_valid, out_sof, out_eof, out_bit, ovf, frame_err
   );

endinterface

// File: rtl/twos_comp_lane.sv
// One serial lane: copy bits up to and including the first 1, then invert the
// rest (two's-complement negation, LSB first). Outputs are registered.
module twos_comp_lane
   import twos_comp_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic beat_i,    // accepted beat
   input  logic sof_i,     // accepted SOF beat
   input  logic eof_i,     // accepted last beat of the word
   input  logic neg_en_i,
   input  logic bit_i,
   output logic out_bit_o,
   output logic ovf_o
);

   lane_state_e state_q, state_d, cur_state;
   logic        neg_q, neg_d, neg;
   logic        out_bit_q, out_bit_d;
   logic        ovf_q, ovf_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StSeek;
         neg_q     <= 1'b0;
         out_bit_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         neg_q     <= neg_d;
         out_bit_q <= out_bit_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      // An SOF beat is evaluated as SEEK with the freshly sampled enable.
      cur_state = sof_i ? StSeek : state_q;
      neg       = sof_i ? neg_en_i : neg_q;
      state_d   = state_q;
      neg_d     = neg_q;
      out_bit_d = out_bit_q;
      ovf_d     = 1'b0;
      if (beat_i) begin
         neg_d = neg;
         unique case (cur_state)
            StSeek: begin
               out_bit_d = bit_i;
               state_d   = (bit_i && neg) ? StInvert : StSeek;
               // Still seeking at the MSB with a 1: input was the most negative value.
               ovf_d     = eof_i && neg && bit_i;
            end
            StInvert: begin
               out_bit_d = ~bit_i;
               state_d   = StInvert;
            end
         endcase
      end
   end

   assign out_bit_o = out_bit_q;
   assign ovf_o     = ovf_q;

endmodule

// File: rtl/twos_comp_serial_mc.sv
// Multi-lane serial two's-complement negator: shared word framing and
// frame-error detection, one twos_comp_lane per channel.
module twos_comp_serial_mc
   import twos_comp_pkg::*;
#(
   parameter int unsigned WIDTH    = DefaultWidth,
   parameter int unsigned CHANNELS = DefaultChannels
) (
   input  logic                  clk,
   input  logic                  rst,
   twos_comp_serial_mc_if.slave  bus
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // cnt_q holds the bit index the next accepted beat will occupy.
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            in_frame_q, in_frame_d;
   logic            out_valid_q, out_valid_d;
   logic            out_sof_q, out_sof_d;
   logic            out_eof_q, out_eof_d;
   logic            frame_err_q, frame_err_d;
   logic            accept, sof_beat, eof_beat;
   logic [CHANNELS-1:0] lane_bit, lane_ovf;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         in_frame_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         in_frame_q  <= in_frame_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      // Non-SOF beats outside a frame are dropped entirely.
      accept      = bus.in_valid && (bus.in_sof || in_frame_q);
      sof_beat    = accept && bus.in_sof;
      eof_beat    = accept && !bus.in_sof && (cnt_q == CntW'(WIDTH - 1));
      cnt_d       = cnt_q;
      in_frame_d  = in_frame_q;
      if (sof_beat) begin
         cnt_d      = CntW'(1);
         in_frame_d = 1'b1;
      end else if (eof_beat) begin
         cnt_d      = '0;
         in_frame_d = 1'b0;
      end else if (accept) begin
         cnt_d = cnt_q + CntW'(1);
      end
      frame_err_d = sof_beat && in_frame_q && (cnt_q != '0);
      out_valid_d = accept;
      out_sof_d   = sof_beat;
      out_eof_d   = eof_beat;
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      twos_comp_lane u_lane (
         .clk_i     (clk),
         .rst_ni    (rst),
         .beat_i    (accept),
         .sof_i     (sof_beat),
         .eof_i     (eof_beat),
         .neg_en_i  (bus.neg_en[i]),
         .bit_i     (bus.in_bit[i]),
         .out_bit_o (lane_bit[i]),
         .ovf_o     (lane_ovf[i])
      );
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_sof   = out_sof_q;
   assign bus.out_eof   = out_eof_q;
   assign bus.frame_err = frame_err_q;
   assign bus.out_bit   = lane_bit;
   assign bus.ovf       = lane_ovf;

endmodule

// File: tb/tb_twos_comp_serial_mc.sv
// Directed bench for twos_comp_serial_mc at WIDTH=4, CHANNELS=2; bit vectors
// below are written {lane1, lane0}.
module tb_twos_comp_serial_mc;

   localparam int unsigned W  = 4;
   localparam int unsigned CH = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   passed = 0;
   int   total  = 0;

   twos_comp_serial_mc_if #(.CHANNELS(CH)) bus ();

   twos_comp_serial_mc #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic v, input logic s, input logic [1:0] b, input logic [1:0] n);
      bus.in_valid = v;
      bus.in_sof   = s;
      bus.in_bit   = b;
      bus.neg_en   = n;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic s, input logic e,
                             input logic fe, input logic [1:0] ov, input logic [1:0] ob);
      logic [7:0] obs;
      logic [7:0] exp;
      obs = {bus.out_valid, bus.out_sof, bus.out_eof, bus.frame_err, bus.ovf, bus.out_bit};
      exp = {v, s, e, fe, ov, ob};
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed v/sof/eof/ferr/ovf/bit=%b expected %b", tag, obs, exp);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_bit   = '0;
      bus.neg_en   = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      expect_out("reset", 0, 0, 0, 0, 2'b00, 2'b00);
      rst = 1'b1;

      // Lane0 negates 6 -> -6 (0,1,0,1); lane1 passes 0,1,1,0.
      step(1, 1, 2'b00, 2'b01); expect_out("neg6_b0", 1, 1, 0, 0, 2'b00, 2'b00);
      step(1, 0, 2'b11, 2'b00); expect_out("neg6_b1", 1, 0, 0, 0, 2'b00, 2'b11);
      step(1, 0, 2'b11, 2'b00); expect_out("neg6_b2", 1, 0, 0, 0, 2'b00, 2'b10);
      step(1, 0, 2'b00, 2'b00); expect_out("neg6_b3", 1, 0, 1, 0, 2'b00, 2'b01);
      step(0, 0, 2'b11, 2'b11); expect_out("gap_hold", 0, 0, 0, 0, 2'b00, 2'b01);
      // Out-of-frame non-SOF beat is dropped.
      step(1, 0, 2'b11, 2'b00); expect_out("drop_nosof", 0, 0, 0, 0, 2'b00, 2'b01);

      // Lane0 negates -8 (overflow); lane1 passes 1,0,1,1.
      step(1, 1, 2'b10, 2'b01); expect_out("m8_b0", 1, 1, 0, 0, 2'b00, 2'b10);
      step(1, 0, 2'b00, 2'b00); expect_out("m8_b1", 1, 0, 0, 0, 2'b00, 2'b00);
      step(1, 0, 2'b10, 2'b00); expect_out("m8_b2", 1, 0, 0, 0, 2'b00, 2'b10);
      step(1, 0, 2'b11, 2'b00); expect_out("m8_b3", 1, 0, 1, 0, 2'b01, 2'b11);

      // Same as the first word with a gap after beat 2.
      step(1, 1, 2'b00, 2'b01); expect_out("gap6_b0", 1, 1, 0, 0, 2'b00, 2'b00);
      step(1, 0, 2'b11, 2'b00); expect_out("gap6_b1", 1, 0, 0, 0, 2'b00, 2'b11);
      step(0, 0, 2'b00, 2'b00); expect_out("gap6_gap", 0, 0, 0, 0, 2'b00, 2'b11);
      step(1, 0, 2'b11, 2'b00); expect_out("gap6_b2", 1, 0, 0, 0, 2'b00, 2'b10);
      step(1, 0, 2'b00, 2'b00); expect_out("gap6_b3", 1, 0, 1, 0, 2'b00, 2'b01);

      // SOF on beat 3: frame error, new word 1,0,0,0 negated; lane1 all-zero negated.
      step(1, 1, 2'b00, 2'b01); expect_out("ferr_old0", 1, 1, 0, 0, 2'b00, 2'b00);
      step(1, 0, 2'b11, 2'b00); expect_out("ferr_old1", 1, 0, 0, 0, 2'b00, 2'b11);
      step(1, 1, 2'b01, 2'b11); expect_out("ferr_new0", 1, 1, 0, 1, 2'b00, 2'b01);
      step(1, 0, 2'b00, 2'b00); expect_out("ferr_new1", 1, 0, 0, 0, 2'b00, 2'b01);
      step(1, 0, 2'b00, 2'b00); expect_out("ferr_new2", 1, 0, 0, 0, 2'b00, 2'b01);
      step(1, 0, 2'b00, 2'b00); expect_out("ferr_new3", 1, 0, 1, 0, 2'b00, 2'b01);
      step(0, 0, 2'b00, 2'b00); expect_out("ferr_clear", 0, 0, 0, 0, 2'b00, 2'b01);

      // Reset mid-word clears outputs immediately.
      step(1, 1, 2'b00, 2'b01); expect_out("rst_b0", 1, 1, 0, 0, 2'b00, 2'b00);
      step(1, 0, 2'b11, 2'b00); expect_out("rst_b1", 1, 0, 0, 0, 2'b00, 2'b11);
      rst = 1'b0;
      #1;
      expect_out("rst_async", 0, 0, 0, 0, 2'b00, 2'b00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(1, 0, 2'b11, 2'b00); expect_out("rst_nosof", 0, 0, 0, 0, 2'b00, 2'b00);

      // Back-to-back words: 6 then 1, lane0 negated.
      step(1, 1, 2'b00, 2'b01); expect_out("b2b_a0", 1, 1, 0, 0, 2'b00, 2'b00);
      step(1, 0, 2'b11, 2'b00); expect_out("b2b_a1", 1, 0, 0, 0, 2'b00, 2'b11);
      step(1, 0, 2'b11, 2'b00); expect_out("b2b_a2", 1, 0, 0, 0, 2'b00, 2'b10);
      step(1, 0, 2'b00, 2'b00); expect_out("b2b_a3", 1, 0, 1, 0, 2'b00, 2'b01);
      step(1, 1, 2'b01, 2'b01); expect_out("b2b_b0", 1, 1, 0, 0, 2'b00, 2'b01);
      step(1, 0, 2'b00, 2'b00); expect_out("b2b_b1", 1, 0, 0, 0, 2'b00, 2'b01);
      step(1, 0, 2'b00, 2'b00); expect_out("b2b_b2", 1, 0, 0, 0, 2'b00, 2'b01);
      step(1, 0, 2'b00, 2'b00); expect_out("b2b_b3", 1, 0, 1, 0, 2'b00, 2'b01);
      step(0, 0, 2'b00, 2'b00); expect_out("idle_end", 0, 0, 0, 0, 2'b00, 2'b01);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
